// File: rtl/fm_iq_modulator_if.sv
// FIFO-side bus of the FM IQ modulator: the audio FIFO read port and the
// IQ FIFO write port grouped into one interface.
//
// Handshake: the audio FIFO is first-word-fall-through, so in_dout is valid
// whenever in_empty=0. A one-cycle in_rd_en pulse consumes that word.
// out_din is written when out_wr_en is high for one cycle. out_wr_en is only
// ever raised while out_full=0. in_rd_en is only ever raised for a word that
// was seen with in_empty=0. Every in_rd_en pulse is followed by exactly one
// out_wr_en pulse.
interface fm_iq_modulator_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] in_dout;
   logic                  in_empty;
   logic                  in_rd_en;
   logic [DATA_WIDTH-1:0] out_din;
   logic                  out_full;
   logic                  out_wr_en;

   // The modulator side.
   modport master (
      input  in_dout, in_empty, out_full,
      output in_rd_en, out_din, out_wr_en
   );

   // The FIFO side: it sources samples and sinks IQ words.
   modport slave (
      output in_dout, in_empty, out_full,
      input  in_rd_en, out_din, out_wr_en
   );
endinterface

// File: rtl/fm_iq_modulator.sv
// FM baseband modulator. The module pops signed Q10 audio samples and scales
// each one into a phase increment. It accumulates the phase and looks up
// sine and cosine in a quarter-wave table. It then writes {Q,I} words to the
// IQ FIFO.
// Optional build macro PRE_EMPH_EN adds a first-order pre-emphasis stage
// (state S_PRE) ahead of the phase update.
module fm_iq_modulator #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          PHASE_WIDTH = 32,
   parameter int          QUANT_BITS  = 10,
   parameter logic [31:0] DEV_GAIN    = 32'd4194304,
   parameter int          AMPLITUDE   = 16384
`ifdef PRE_EMPH_EN
   ,
   parameter logic signed [31:0] PE_COEF = 32'sd2048
`endif
) (
   input  logic                   clock,
   input  logic                   reset,
   fm_iq_modulator_if.master      bus,
   output logic [2:0]             dbg_state_o,
   output logic [PHASE_WIDTH-1:0] dbg_phase_o
);

   typedef enum logic [2:0] {
      S_READ  = 3'd0,
      S_PHASE = 3'd1,
      S_LUT   = 3'd2,
      S_WRITE = 3'd3
`ifdef PRE_EMPH_EN
      ,
      S_PRE   = 3'd4
`endif
   } state_e;

   // Quarter-wave table s[k] = round(AMPLITUDE*sin(2*pi*k/1024)), k = 0..256.
   // It is built at elaboration with an integer Taylor series in Q30. That
   // keeps the table exact to far below one output LSB without real math.
   function automatic logic [257*16-1:0] build_sin_lut();
      logic [257*16-1:0] lut;
      longint            x;
      longint            x2;
      longint            term;
      longint            acc;
      lut = '0;
      for (int k = 0; k <= 256; k++) begin
         // x = pi*k/512 in Q30; pi is held in Q40 for headroom
         x    = (longint'(k) * 64'sd3454217652358) >>> 19;
         x2   = (x * x) >>> 30;
         term = x;
         acc  = x;
         for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
         end
         lut[k*16 +: 16] = 16'((acc * longint'(AMPLITUDE) + 64'sd536870912) >>> 30);
      end
      return lut;
   endfunction

   localparam logic [257*16-1:0] SIN_LUT = build_sin_lut();

   // Full-wave sine from the quarter table. Bit 8 mirrors the index and
   // bit 9 negates the result.
   function automatic logic [15:0] quarter_wave(input logic [9:0] j);
      logic [8:0]  r;
      logic [15:0] mag;
      r   = j[8] ? (9'd256 - {1'b0, j[7:0]}) : {1'b0, j[7:0]};
      mag = SIN_LUT[{r, 4'b0000} +: 16];
      return j[9] ? -mag : mag;
   endfunction

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   sample_q, sample_d;
   logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
   logic [15:0]             i_q, i_d;
   logic [15:0]             q_q, q_d;
   logic                    rd_en_q, rd_en_d;
   logic                    wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0]   out_din_q, out_din_d;

   logic signed [63:0]      sample_ext;
   logic signed [63:0]      prod;
   logic [9:0]              idx;

   assign sample_ext = {{(64-DATA_WIDTH){sample_q[DATA_WIDTH-1]}}, sample_q};
   // The gain is unsigned, so it is zero-extended. The product is 64-bit signed.
   assign prod       = sample_ext * $signed({32'd0, DEV_GAIN});
   assign idx        = phase_q[PHASE_WIDTH-1 -: 10];

`ifdef PRE_EMPH_EN
   logic [DATA_WIDTH-1:0]   x_prev_q, x_prev_d;
   logic signed [63:0]      prev_ext;
   logic signed [63:0]      coef_ext;
   logic signed [63:0]      emph_prod;
   logic [DATA_WIDTH-1:0]   y_pre;

   assign prev_ext  = {{(64-DATA_WIDTH){x_prev_q[DATA_WIDTH-1]}}, x_prev_q};
   assign coef_ext  = {{32{PE_COEF[31]}}, PE_COEF};
   assign emph_prod = (sample_ext - prev_ext) * coef_ext;
   assign y_pre     = DATA_WIDTH'(sample_ext + (emph_prod >>> QUANT_BITS));
`endif

   // Next-state and registered-output logic for the read/phase/lut/write sequence.
   always_comb begin
      state_d   = state_q;
      sample_d  = sample_q;
      phase_d   = phase_q;
      i_d       = i_q;
      q_d       = q_q;
      rd_en_d   = 1'b0;
      wr_en_d   = 1'b0;
      out_din_d = out_din_q;
`ifdef PRE_EMPH_EN
      x_prev_d  = x_prev_q;
`endif
      case (state_q)
         S_READ: begin
            if (!bus.in_empty) begin
               sample_d = bus.in_dout;
               rd_en_d  = 1'b1;
`ifdef PRE_EMPH_EN
               state_d  = S_PRE;
`else
               state_d  = S_PHASE;
`endif
            end
         end
`ifdef PRE_EMPH_EN
         S_PRE: begin
            sample_d = y_pre;
            x_prev_d = sample_q;
            state_d  = S_PHASE;
         end
`endif
         S_PHASE: begin
            // Negative samples give negative increments. The wrap is modulo 2^PHASE_WIDTH.
            phase_d = phase_q + PHASE_WIDTH'(prod >>> QUANT_BITS);
            state_d = S_LUT;
         end
         S_LUT: begin
            q_d     = quarter_wave(idx);
            i_d     = quarter_wave(idx + 10'd256);
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (!bus.out_full) begin
               wr_en_d   = 1'b1;
               out_din_d = DATA_WIDTH'({q_q, i_q});
               state_d   = S_READ;
            end
         end
         default: state_d = S_READ;
      endcase
   end

   // State and datapath registers. Reset clears everything and drops any
   // sample that is still in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= S_READ;
         sample_q  <= '0;
         phase_q   <= '0;
         i_q       <= '0;
         q_q       <= '0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         out_din_q <= '0;
`ifdef PRE_EMPH_EN
         x_prev_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sample_q  <= sample_d;
         phase_q   <= phase_d;
         i_q       <= i_d;
         q_q       <= q_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         out_din_q <= out_din_d;
`ifdef PRE_EMPH_EN
         x_prev_q  <= x_prev_d;
`endif
      end
   end

   assign bus.in_rd_en  = rd_en_q;
   assign bus.out_wr_en = wr_en_q;
   assign bus.out_din   = out_din_q;
   assign dbg_state_o   = state_q;
   assign dbg_phase_o   = phase_q;

endmodule

// File: tb/tb_fm_iq_modulator.sv
// Directed self-checking bench for fm_iq_modulator.
module tb_fm_iq_modulator;
   localparam int DW = 32;
   localparam logic [2:0] ST_READ  = 3'd0;
   localparam logic [2:0] ST_LUT   = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
`ifdef PRE_EMPH_EN
   localparam int LAT    = 4;
   localparam int PERIOD = 5;
`else
   localparam int LAT    = 3;
   localparam int PERIOD = 4;
`endif

   logic          clock;
   logic          reset;
   logic [2:0]    dbg_state;
   logic [31:0]   dbg_phase;

   int            cyc    = 0;
   int            checks = 0;
   int            errors = 0;

   logic [DW-1:0] src     [8];
   int            pop_cyc [8];
   int            wr_cyc  [8];
   logic [DW-1:0] words   [8];
   int            rd_extra;
   bit            stream_timeout;
   logic [DW-1:0] exp_q[$];

   fm_iq_modulator_if #(.DATA_WIDTH(DW)) bus ();

   fm_iq_modulator dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state),
      .dbg_phase_o (dbg_phase)
   );

   // clock / cycle counter
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      bus.in_empty = 1'b1;
      bus.in_dout  = '0;
      bus.out_full = 1'b0;
      reset        = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
   endtask

   // Feeds src[0..n-1] as a FWFT FIFO would, with out_full=0. For each
   // sample it records the pop cycle, the write cycle and the written word.
   task automatic drive_stream(input int n);
      int guard;
      stream_timeout = 1'b0;
      rd_extra       = 0;
      @(negedge clock);
      bus.in_dout  = src[0];
      bus.in_empty = 1'b0;
      for (int s = 0; s < n; s++) begin
         guard = 0;
         while (bus.in_rd_en !== 1'b1 && guard < 40) begin
            @(negedge clock);
            guard++;
         end
         if (bus.in_rd_en !== 1'b1) begin
            stream_timeout = 1'b1;
            bus.in_empty   = 1'b1;
            return;
         end
         pop_cyc[s] = cyc;
         if (s + 1 < n) bus.in_dout = src[s+1];
         else           bus.in_empty = 1'b1;
         guard = 0;
         while (bus.out_wr_en !== 1'b1 && guard < 40) begin
            @(negedge clock);
            guard++;
            if (bus.in_rd_en === 1'b1) rd_extra++;
         end
         if (bus.out_wr_en !== 1'b1) begin
            stream_timeout = 1'b1;
            bus.in_empty   = 1'b1;
            return;
         end
         wr_cyc[s] = cyc;
         words[s]  = bus.out_din;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      checks++; if (bus.out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", bus.out_wr_en); end
      checks++; if (bus.in_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", bus.in_rd_en); end
      checks++; if (bus.out_din !== 32'h0) begin errors++; $display("FAIL reset_out_din got %h exp 00000000", bus.out_din); end
      checks++; if (dbg_phase !== 32'h0) begin errors++; $display("FAIL reset_phase got %h exp 00000000", dbg_phase); end
      checks++; if (dbg_state !== ST_READ) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_READ); end
   endtask

   task automatic test_idle_empty();
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checks++;
         if (bus.in_rd_en !== 1'b0 || bus.out_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_empty cycle %0d rd_en %b wr_en %b exp 0 0", i, bus.in_rd_en, bus.out_wr_en);
         end
      end
   endtask

   task automatic test_zero_sample();
      apply_reset();
      src[0] = 32'h0;
      drive_stream(1);
      checks++; if (stream_timeout) begin errors++; $display("FAIL zero_timeout got timeout exp write"); end
      checks++; if (words[0] !== 32'h00004000) begin errors++; $display("FAIL zero_word got %h exp 00004000", words[0]); end
      checks++; if (wr_cyc[0] - pop_cyc[0] !== LAT) begin errors++; $display("FAIL zero_latency got %0d exp %0d", wr_cyc[0] - pop_cyc[0], LAT); end
      checks++; if (rd_extra !== 0) begin errors++; $display("FAIL zero_rd_pulse extra rd cycles %0d exp 0", rd_extra); end
      @(negedge clock);
      checks++; if (bus.out_wr_en !== 1'b0) begin errors++; $display("FAIL zero_wr_pulse got %b exp 0", bus.out_wr_en); end
      checks++; if (bus.out_din !== 32'h00004000) begin errors++; $display("FAIL zero_din_hold got %h exp 00004000", bus.out_din); end
      checks++; if (bus.in_rd_en !== 1'b0) begin errors++; $display("FAIL zero_no_pop got %b exp 0", bus.in_rd_en); end
   endtask

`ifndef PRE_EMPH_EN
   task automatic test_quarter_turns();
      logic [DW-1:0] exp;
      apply_reset();
      for (int i = 0; i < 4; i++) src[i] = 32'd262144;
      exp_q = '{32'h40000000, 32'h0000C000, 32'hC0000000, 32'h00004000};
      drive_stream(4);
      checks++; if (stream_timeout) begin errors++; $display("FAIL quarter_timeout got timeout exp 4 writes"); end
      for (int i = 0; i < 4; i++) begin
         exp = exp_q.pop_front();
         checks++; if (words[i] !== exp) begin errors++; $display("FAIL quarter_word[%0d] got %h exp %h", i, words[i], exp); end
         checks++; if (wr_cyc[i] - pop_cyc[i] !== LAT) begin errors++; $display("FAIL quarter_latency[%0d] got %0d exp %0d", i, wr_cyc[i] - pop_cyc[i], LAT); end
      end
      checks++; if (dbg_phase !== 32'h0) begin errors++; $display("FAIL quarter_wrap_phase got %h exp 00000000", dbg_phase); end
   endtask

   task automatic test_small_steps();
      logic [DW-1:0] exp;
      apply_reset();
      for (int i = 0; i < 4; i++) src[i] = 32'd1024;
      // idx 1..4: {round(16384*sin), round(16384*cos)}
      exp_q = '{32'h00654000, 32'h00C93FFF, 32'h012E3FFD, 32'h01923FFB};
      drive_stream(4);
      checks++; if (stream_timeout) begin errors++; $display("FAIL small_timeout got timeout exp 4 writes"); end
      for (int i = 0; i < 4; i++) begin
         exp = exp_q.pop_front();
         checks++; if (words[i] !== exp) begin errors++; $display("FAIL small_word[%0d] got %h exp %h", i, words[i], exp); end
      end
      checks++; if (dbg_phase !== 32'h01000000) begin errors++; $display("FAIL small_phase got %h exp 01000000", dbg_phase); end
   endtask

   task automatic test_negative();
      apply_reset();
      src[0] = 32'hFFFC0000;
      drive_stream(1);
      checks++; if (stream_timeout) begin errors++; $display("FAIL negative_timeout got timeout exp write"); end
      checks++; if (words[0] !== 32'hC0000000) begin errors++; $display("FAIL negative_word got %h exp C0000000", words[0]); end
      checks++; if (dbg_phase !== 32'hC0000000) begin errors++; $display("FAIL negative_phase got %h exp C0000000", dbg_phase); end
   endtask
`else
   task automatic test_pre_emphasis();
      apply_reset();
      src[0] = 32'd1024;
      src[1] = 32'd1024;
      drive_stream(2);
      checks++; if (stream_timeout) begin errors++; $display("FAIL pre_timeout got timeout exp 2 writes"); end
      checks++; if (words[0] !== 32'h012E3FFD) begin errors++; $display("FAIL pre_word0 got %h exp 012E3FFD", words[0]); end
      checks++; if (words[1] !== 32'h01923FFB) begin errors++; $display("FAIL pre_word1 got %h exp 01923FFB", words[1]); end
      checks++; if (wr_cyc[0] - pop_cyc[0] !== 4) begin errors++; $display("FAIL pre_latency got %0d exp 4", wr_cyc[0] - pop_cyc[0]); end
   endtask
`endif

   task automatic test_back_to_back();
      apply_reset();
      src[0] = 32'd262144;
      src[1] = 32'd262144;
      drive_stream(2);
      checks++; if (stream_timeout) begin errors++; $display("FAIL b2b_timeout got timeout exp 2 writes"); end
      checks++; if (pop_cyc[1] - pop_cyc[0] !== PERIOD) begin errors++; $display("FAIL b2b_period got %0d exp %0d", pop_cyc[1] - pop_cyc[0], PERIOD); end
`ifdef PRE_EMPH_EN
      checks++; if (words[0] !== 32'hC0000000) begin errors++; $display("FAIL b2b_word0 got %h exp C0000000", words[0]); end
      checks++; if (words[1] !== 32'h00004000) begin errors++; $display("FAIL b2b_word1 got %h exp 00004000", words[1]); end
`else
      checks++; if (words[0] !== 32'h40000000) begin errors++; $display("FAIL b2b_word0 got %h exp 40000000", words[0]); end
      checks++; if (words[1] !== 32'h0000C000) begin errors++; $display("FAIL b2b_word1 got %h exp 0000C000", words[1]); end
`endif
   endtask

   task automatic test_out_full_hold();
      int guard;
      apply_reset();
      bus.out_full = 1'b1;
      @(negedge clock);
      bus.in_dout  = 32'd262144;
      bus.in_empty = 1'b0;
      guard = 0;
      while (bus.in_rd_en !== 1'b1 && guard < 40) begin @(negedge clock); guard++; end
      checks++; if (bus.in_rd_en !== 1'b1) begin errors++; $display("FAIL full_first_pop got %b exp 1", bus.in_rd_en); end
      // a second sample stays available; it must not be popped while stalled
      bus.in_dout = 32'h0;
      guard = 0;
      while (dbg_state !== ST_WRITE && guard < 40) begin @(negedge clock); guard++; end
      checks++; if (dbg_state !== ST_WRITE) begin errors++; $display("FAIL full_reach_write got state %0d exp %0d", dbg_state, ST_WRITE); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         checks++;
         if (bus.out_wr_en !== 1'b0 || bus.in_rd_en !== 1'b0 || bus.out_din !== 32'h0 || dbg_state !== ST_WRITE) begin
            errors++;
            $display("FAIL full_hold cycle %0d wr_en %b rd_en %b din %h state %0d exp 0 0 00000000 %0d",
                     i, bus.out_wr_en, bus.in_rd_en, bus.out_din, dbg_state, ST_WRITE);
         end
      end
      bus.out_full = 1'b0;
      @(negedge clock);
      checks++; if (bus.out_wr_en !== 1'b1) begin errors++; $display("FAIL full_release_wr got %b exp 1", bus.out_wr_en); end
`ifdef PRE_EMPH_EN
      checks++; if (bus.out_din !== 32'hC0000000) begin errors++; $display("FAIL full_release_word got %h exp C0000000", bus.out_din); end
`else
      checks++; if (bus.out_din !== 32'h40000000) begin errors++; $display("FAIL full_release_word got %h exp 40000000", bus.out_din); end
`endif
      // drain the second sample: both builds land on a quarter turn
      guard = 0;
      while (bus.in_rd_en !== 1'b1 && guard < 40) begin @(negedge clock); guard++; end
      bus.in_empty = 1'b1;
      guard = 0;
      while (bus.out_wr_en !== 1'b1 && guard < 40) begin @(negedge clock); guard++; end
      checks++; if (bus.out_wr_en !== 1'b1) begin errors++; $display("FAIL full_drain_timeout got no write exp write"); end
      checks++; if (bus.out_din !== 32'h40000000) begin errors++; $display("FAIL full_drain_word got %h exp 40000000", bus.out_din); end
   endtask

   task automatic test_reset_in_lut();
      int guard;
      apply_reset();
      src[0] = 32'd262144;
      drive_stream(1);
      checks++; if (stream_timeout) begin errors++; $display("FAIL rlut_first_timeout got timeout exp write"); end
      @(negedge clock);
      bus.in_dout  = 32'd262144;
      bus.in_empty = 1'b0;
      guard = 0;
      while (bus.in_rd_en !== 1'b1 && guard < 40) begin @(negedge clock); guard++; end
      bus.in_empty = 1'b1;
      guard = 0;
      while (dbg_state !== ST_LUT && guard < 40) begin @(negedge clock); guard++; end
      checks++; if (dbg_state !== ST_LUT) begin errors++; $display("FAIL rlut_reach_lut got state %0d exp %0d", dbg_state, ST_LUT); end
      reset = 1'b0;
      @(negedge clock);
      checks++; if (bus.out_wr_en !== 1'b0) begin errors++; $display("FAIL rlut_wr_en got %b exp 0", bus.out_wr_en); end
      checks++; if (bus.out_din !== 32'h0) begin errors++; $display("FAIL rlut_out_din got %h exp 00000000", bus.out_din); end
      checks++; if (dbg_phase !== 32'h0) begin errors++; $display("FAIL rlut_phase got %h exp 00000000", dbg_phase); end
      checks++; if (dbg_state !== ST_READ) begin errors++; $display("FAIL rlut_state got %0d exp %0d", dbg_state, ST_READ); end
      reset = 1'b1;
      src[0] = 32'h0;
      drive_stream(1);
      checks++; if (stream_timeout) begin errors++; $display("FAIL rlut_after_timeout got timeout exp write"); end
      checks++; if (words[0] !== 32'h00004000) begin errors++; $display("FAIL rlut_after_word got %h exp 00004000", words[0]); end
      checks++; if (wr_cyc[0] - pop_cyc[0] !== LAT) begin errors++; $display("FAIL rlut_after_latency got %0d exp %0d", wr_cyc[0] - pop_cyc[0], LAT); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      reset        = 1'b0;
      bus.in_empty = 1'b1;
      bus.in_dout  = '0;
      bus.out_full = 1'b0;
      test_reset();
      test_idle_empty();
      test_zero_sample();
`ifndef PRE_EMPH_EN
      test_quarter_turns();
      test_small_steps();
      test_negative();
`else
      test_pre_emphasis();
`endif
      test_back_to_back();
      test_out_full_hold();
      test_reset_in_lut();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
